// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO division sequencer: operation encodings,
// controller state enum and the default datapath width.
package hilo_pkg;

  localparam int HILO_WIDTH = 32;

  localparam logic [2:0] OP_DIV  = 3'd0;
  localparam logic [2:0] OP_DIVU = 3'd1;
  localparam logic [2:0] OP_MTHI = 3'd2;
  localparam logic [2:0] OP_MTLO = 3'd3;
  localparam logic [2:0] OP_MFHI = 3'd4;
  localparam logic [2:0] OP_MFLO = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/hilo_reg.sv
// Architectural HI/LO register pair with independent write enables.
module hilo_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             hi_we,
  input  logic [WIDTH-1:0] hi_d,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] lo_d,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // HI and LO load independently so MTHI/MTLO touch only their own half.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (hi_we) hi <= hi_d;
      if (lo_we) lo <= lo_d;
    end
  end

endmodule

// File: rtl/hilo_div_ctrl.sv
// Sequencer between EX and the iterative divider. Launches DIV/DIVU, stalls
// the pipeline while the divider runs, owns HI/LO and drains divisions that
// were killed by a flush (the divider cannot be aborted).
// Optional build macro: DIV_ZERO_SKIP_EN -- a zero divisor does not launch
// the divider and leaves HI/LO untouched.
module hilo_div_ctrl
  import hilo_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_start,
  output logic             div_signed,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder
);

  state_t           state, state_nxt;
  logic             launch;
  logic             zero_skip;
  logic             done_eff;
  logic             hi_we, lo_we;
  logic [WIDTH-1:0] hi_d, lo_d;

`ifdef DIV_ZERO_SKIP_EN
  assign zero_skip = (op_b == '0);
`else
  assign zero_skip = 1'b0;
`endif

  // A done seen during the launch pulse belongs to no live division.
  assign done_eff = div_done & ~div_start;

  // Next-state, stall and HI/LO write decode.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    stall     = 1'b0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    hi_d      = op_a;
    lo_d      = op_a;
    case (state)
      ST_IDLE: begin
        if (op_valid && !flush) begin
          if (is_div_op(op_code) && !zero_skip) begin
            launch    = 1'b1;
            stall     = 1'b1;
            state_nxt = ST_BUSY;
          end else if (op_code == OP_MTHI) begin
            hi_we = 1'b1;
          end else if (op_code == OP_MTLO) begin
            lo_we = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (flush) begin
          // A flush coinciding with done finishes the divider; nothing to drain.
          state_nxt = done_eff ? ST_IDLE : ST_DRAIN;
        end else if (done_eff) begin
          hi_we     = 1'b1;
          lo_we     = 1'b1;
          hi_d      = div_remainder;
          lo_d      = div_quotient;
          state_nxt = ST_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      ST_DRAIN: begin
        stall = op_valid;
        if (done_eff) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Launch pulse and operand latch; operands hold until the next launch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_start    <= 1'b0;
      div_signed   <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
    end else begin
      div_start <= launch;
      if (launch) begin
        div_signed   <= (op_code == OP_DIV);
        div_dividend <= op_a;
        div_divisor  <= op_b;
      end
    end
  end

  hilo_reg #(.WIDTH(WIDTH)) u_hilo_reg (
    .clk    (clk),
    .resetn (resetn),
    .hi_we  (hi_we),
    .hi_d   (hi_d),
    .lo_we  (lo_we),
    .lo_d   (lo_d),
    .hi     (hi),
    .lo     (lo)
  );

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Testbench for hilo_div_ctrl with a behavioural fixed-latency divider.
module tb_hilo_div_ctrl;
  import hilo_pkg::*;

  localparam int W   = 32;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         op_valid = 1'b0;
  logic [2:0]   op_code = OP_MFHI;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         flush = 1'b0;
  logic         stall;
  logic [W-1:0] hi, lo;
  logic         div_start, div_signed;
  logic [W-1:0] div_dividend, div_divisor;
  logic         div_done = 1'b0;
  logic [W-1:0] div_quotient = '0;
  logic [W-1:0] div_remainder = '0;

  hilo_div_ctrl #(.WIDTH(W)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .op_valid      (op_valid),
    .op_code       (op_code),
    .op_a          (op_a),
    .op_b          (op_b),
    .flush         (flush),
    .stall         (stall),
    .hi            (hi),
    .lo            (lo),
    .div_start     (div_start),
    .div_signed    (div_signed),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_done      (div_done),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Divider model: results appear LAT cycles after the launch pulse.
  int           pend = 0;
  int           start_cnt = 0;
  logic         last_signed = 1'b0;
  logic [W-1:0] last_dvd = '0, last_dvs = '0;
  logic [W-1:0] m_q = '0, m_r = '0;
  logic signed [W-1:0] sa, sb;

  always @(negedge clk) begin
    if (div_done) div_done = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        div_done      = 1'b1;
        div_quotient  = m_q;
        div_remainder = m_r;
      end
    end
    if (div_start) begin
      start_cnt++;
      last_signed = div_signed;
      last_dvd    = div_dividend;
      last_dvs    = div_divisor;
      pend        = LAT - 1;
      if (div_divisor == '0) begin
        m_q = '1;
        m_r = div_dividend;
      end else if (div_signed) begin
        sa  = div_dividend;
        sb  = div_divisor;
        m_q = sa / sb;
        m_r = sa % sb;
      end else begin
        m_q = div_dividend / div_divisor;
        m_r = div_dividend % div_divisor;
      end
    end
  end

  logic [2*W-1:0] exp_q[$];

  // Sample stall each cycle until the EX instruction is released.
  task automatic wait_accept(input string nm, output int ns);
    bit ok;
    ns = 0;
    ok = 0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (!stall) begin
        ok = 1;
        break;
      end
      ns++;
      @(negedge clk);
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL %s: stall never released within 60 cycles", nm);
    end
  endtask

  // Retire the instruction and compare HI/LO against the scoreboard head.
  task automatic retire(input string nm);
    logic [2*W-1:0] e;
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = exp_q.pop_front();
      chk({nm, " hi"}, hi, e[2*W-1:W]);
      chk({nm, " lo"}, lo, e[W-1:0]);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    op_valid = 1'b1;
    op_code  = op;
    op_a     = a;
    op_b     = b;
  endtask

  task automatic run_op(input string nm, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo, input int estall, input int estart);
    int s0, ns;
    exp_q.push_back({ehi, elo});
    s0 = start_cnt;
    @(negedge clk);
    drive(op, a, b);
    wait_accept(nm, ns);
    retire(nm);
    chk({nm, " stall cycles"}, ns, estall);
    chk({nm, " start pulses"}, start_cnt - s0, estart);
    if (estart != 0) begin
      chk({nm, " dividend"}, last_dvd, a);
      chk({nm, " divisor"}, last_dvs, b);
      chk({nm, " signed"}, {31'b0, last_signed}, {31'b0, op == OP_DIV});
    end
  endtask

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a, b, ehi, elo;
    int           estall, estart;
  } vec_t;

  vec_t vecs[10];
  int   ns, s0;

  initial begin
    vecs[0] = '{"divu_200_100", OP_DIVU, 32'h00000200, 32'h00000100, 32'h00000000, 32'h00000002, LAT, 1};
    vecs[1] = '{"div_neg_small", OP_DIV, 32'hEEBAEBE7, 32'hE67EF001, 32'hEEBAEBE7, 32'h00000000, LAT, 1};
    vecs[2] = '{"divu_7_2", OP_DIVU, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, LAT, 1};
    vecs[3] = '{"div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, LAT, 1};
    vecs[4] = '{"div_7_m2", OP_DIV, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, LAT, 1};
    vecs[5] = '{"divu_big_2", OP_DIVU, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, LAT, 1};
    vecs[6] = '{"mthi", OP_MTHI, 32'h12345678, 32'h0, 32'h12345678, 32'h7FFFFFFC, 0, 0};
    vecs[7] = '{"mfhi", OP_MFHI, 32'h0, 32'h0, 32'h12345678, 32'h7FFFFFFC, 0, 0};
    vecs[8] = '{"mtlo", OP_MTLO, 32'hA5A5A5A5, 32'h0, 32'h12345678, 32'hA5A5A5A5, 0, 0};
    vecs[9] = '{"mflo", OP_MFLO, 32'h0, 32'h0, 32'h12345678, 32'hA5A5A5A5, 0, 0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst hi", hi, '0);
    chk("rst lo", lo, '0);
    chk("rst div_start", {31'b0, div_start}, '0);
    chk("rst div_signed", {31'b0, div_signed}, '0);
    chk("rst dividend", div_dividend, '0);
    chk("rst divisor", div_divisor, '0);
    chk("rst stall", {31'b0, stall}, '0);
    @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo,
             vecs[i].estall, vecs[i].estart);

    // Flush two cycles after launch, then a DIVU waits out the drain
    @(negedge clk);
    drive(OP_DIVU, 32'h80000001, 32'h00000002);
    #1 chk("flush issue stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    #1 chk("flush start pulse", {31'b0, div_start}, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    #1 chk("flush kill stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    drive(OP_DIVU, 32'hFFFFFFFF, 32'h00000001);
    exp_q.push_back({32'h00000000, 32'hFFFFFFFF});
    s0 = start_cnt;
    #1 chk("drain stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    #1 chk("drain done stall", {31'b0, stall}, 32'd1);
    chk("drain done seen", {31'b0, div_done}, 32'd1);
    @(negedge clk);
    #1 chk("drain hi kept", hi, 32'h12345678);
    chk("drain lo kept", lo, 32'hA5A5A5A5);
    chk("drain relaunch stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    wait_accept("after_drain", ns);
    retire("after_drain");
    chk("after_drain stall cycles", ns, LAT - 1);
    chk("after_drain start pulses", start_cnt - s0, 32'd1);

    // Reset asserted mid-BUSY, stale done arrives afterwards
    @(negedge clk);
    drive(OP_DIVU, 32'h00000009, 32'h00000002);
    @(negedge clk);
    @(negedge clk);
    resetn   = 1'b0;
    op_valid = 1'b0;
    #1 chk("midrst hi", hi, '0);
    chk("midrst lo", lo, '0);
    chk("midrst div_start", {31'b0, div_start}, '0);
    chk("midrst dividend", div_dividend, '0);
    chk("midrst stall", {31'b0, stall}, '0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    #1 chk("stale done present", {31'b0, div_done}, 32'd1);
    chk("stale done stall", {31'b0, stall}, '0);
    @(negedge clk);
    #1 chk("stale hi", hi, '0);
    chk("stale lo", lo, '0);
    chk("stale div_start", {31'b0, div_start}, '0);

    // Recovery after reset
    run_op("recover", OP_DIVU, 32'h00000200, 32'h00000100, 32'h0, 32'h2, LAT, 1);
    run_op("mthi_pre_zero", OP_MTHI, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 32'h2, 0, 0);

    // Division by zero
`ifdef DIV_ZERO_SKIP_EN
    run_op("div_zero", OP_DIV, 32'h00001234, 32'h0, 32'hCAFEF00D, 32'h2, 0, 0);
`else
    run_op("div_zero", OP_DIV, 32'h00001234, 32'h0, 32'h00001234, 32'hFFFFFFFF, LAT, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
